sm_to_bcd: RTL and testbench

SM_TO_BCD -- requirements
Module: sm_to_bcd

---
 rtl/sm_pkg.sv | 30 +++
 rtl/bcd_add3.sv | 15 +
 rtl/sm_to_bcd.sv | 123 ++++++++++++
 tb/tb_sm_to_bcd.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared constants for the sign-magnitude to BCD path: FSM state encoding,
// BCD digit geometry and the double-dabble correction threshold.
package sm_pkg;

    // Converter FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    // One BCD digit is one nibble
    localparam int NIBBLE_W = 4;

    // Digits at or above this value are corrected by +3 before each shift
    localparam int ADD3_THRESH = 5;

    // 10^d, saturating at the all-ones value instead of wrapping
    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < d; i++) begin
            if (r > 64'd1844674407370955161) begin
                r = '1;
            end else begin
                r = r * 64'd10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5..15 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import sm_pkg::*;
(
    input  logic [NIBBLE_W-1:0] din,
    output logic [NIBBLE_W-1:0] dout
);

    // Conditional +3 on a single digit
    always_comb begin
        dout = (din >= NIBBLE_W'(ADD3_THRESH)) ? din + NIBBLE_W'(3) : din;
    end

endmodule

// File: rtl/sm_to_bcd.sv
// Sign-magnitude to packed-BCD converter. Accepts one operand while idle,
// runs N-1 double-dabble steps, then publishes sign and digits with a
// one-cycle done pulse. Latency is a fixed N cycles from the accept edge.
module sm_to_bcd
    import sm_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N-1:0]       sm_in,
    output logic               ready,
    output logic               done,
    output logic               neg,
    output logic [4*D-1:0]     bcd
);

    localparam int MW = N - 1;            // magnitude width
    localparam int CW = $clog2(N);        // iteration counter width
    localparam int BW = NIBBLE_W * D;     // BCD scratch width
    localparam longint unsigned MAX_MAG = (64'd1 << MW) - 64'd1;

    // Reject parameter sets where the largest magnitude cannot fit in D digits
    if (N < 2) begin : g_bad_n
        $error("sm_to_bcd: N must be at least 2");
    end
    if (pow10(D) <= MAX_MAG) begin : g_bad_d
        $error("sm_to_bcd: D digits cannot represent the largest magnitude");
    end

    logic [1:0]    state_q,    state_d;
    logic [MW-1:0] mag_q,      mag_d;
    logic [BW-1:0] scratch_q,  scratch_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic          neg_pend_q, neg_pend_d;
    logic          done_q,     done_d;
    logic          neg_q,      neg_d;
    logic [BW-1:0] bcd_q,      bcd_d;
    logic [BW-1:0] corrected;

    // One correction cell per scratch digit
    for (genvar g = 0; g < D; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (scratch_q[g*NIBBLE_W +: NIBBLE_W]),
            .dout (corrected[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // Next-state and datapath update for the three-state converter
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        neg_pend_d = neg_pend_q;
        neg_d      = neg_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d      = sm_in[MW-1:0];
                    // Negative zero is folded to positive here, once, at capture
                    neg_pend_d = sm_in[N-1] & (|sm_in[MW-1:0]);
                    scratch_d  = '0;
                    cnt_d      = CW'(MW);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The bit shifted out of the top digit is always zero for legal N/D
                {scratch_d, mag_d} = {corrected, mag_q} << 1;
                cnt_d              = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = scratch_q;
                neg_d   = neg_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that dominates start
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            neg_pend_q <= 1'b0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            neg_pend_q <= neg_pend_d;
            done_q     <= done_d;
            neg_q      <= neg_d;
            bcd_q      <= bcd_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign neg   = neg_q;
    assign bcd   = bcd_q;

endmodule

// File: tb/tb_sm_to_bcd.sv
// Self-checking bench for sm_to_bcd (N=8, D=3). Expected results come from
// plain decimal arithmetic on the operand; stimulus is directed plus random.
module tb_sm_to_bcd;

    localparam int N   = 8;
    localparam int D   = 3;
    localparam int LAT = N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  sm_in;
    logic          ready;
    logic          done;
    logic          neg;
    logic [4*D-1:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;

    sm_to_bcd #(.N(N), .D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sm_in (sm_in),
        .ready (ready),
        .done  (done),
        .neg   (neg),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of the magnitude
    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = int'(v[6:0]);
        return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
    endfunction

    // Reference: negative only when the magnitude is non-zero
    function automatic logic ref_neg(input logic [7:0] v);
        return v[7] && (v[6:0] != 7'd0);
    endfunction

    // Present v with start for one edge; returns 1 time unit after the accept edge
    task automatic accept(input logic [7:0] v);
        sm_in = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (0 if it never comes within the budget)
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        sm_in = 8'h85;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg: got %b expected 0", neg); end
        n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ignored: ready got %b expected 1", ready); end
    endtask

    task automatic test_directed();
        logic [7:0] vecs [5];
        int lat;
        vecs = '{8'h85, 8'h7F, 8'hFF, 8'h80, 8'h00};
        foreach (vecs[i]) begin
            accept(vecs[i]);
            wait_done(lat);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir_latency %h: got %0d expected %0d", vecs[i], lat, LAT); end
            n_checks++; if (neg !== ref_neg(vecs[i])) begin n_fail++; $display("FAIL dir_neg %h: got %b expected %b", vecs[i], neg, ref_neg(vecs[i])); end
            n_checks++; if (bcd !== ref_bcd(vecs[i])) begin n_fail++; $display("FAIL dir_bcd %h: got %h expected %h", vecs[i], bcd, ref_bcd(vecs[i])); end
            n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready_in_done %h: got %b expected 1", vecs[i], ready); end
            @(posedge clk); #1;
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse %h: got %b expected 0", vecs[i], done); end
            n_checks++; if (bcd !== ref_bcd(vecs[i])) begin n_fail++; $display("FAIL dir_bcd_hold %h: got %h expected %h", vecs[i], bcd, ref_bcd(vecs[i])); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  seq [3];
        int          done_at [$];
        logic [11:0] got_bcd [$];
        logic        got_neg [$];
        seq = '{8'h0C, 8'h8C, 8'h64};
        sm_in = seq[0];
        start = 1'b1;
        @(posedge clk); #1;
        sm_in = seq[1];
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_at.push_back(k);
                got_bcd.push_back(bcd);
                got_neg.push_back(neg);
            end
            if (k == 9)  sm_in = seq[2];
            if (k == 18) start = 1'b0;
        end
        n_checks++; if (done_at.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", done_at.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < done_at.size()) begin
                n_checks++; if (done_at[i] != LAT + (LAT + 1) * i) begin n_fail++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, done_at[i], LAT + (LAT + 1) * i); end
                n_checks++; if (got_bcd[i] !== ref_bcd(seq[i])) begin n_fail++; $display("FAIL b2b_bcd[%0d]: got %h expected %h", i, got_bcd[i], ref_bcd(seq[i])); end
                n_checks++; if (got_neg[i] !== ref_neg(seq[i])) begin n_fail++; $display("FAIL b2b_neg[%0d]: got %b expected %b", i, got_neg[i], ref_neg(seq[i])); end
            end
        end
    endtask

    task automatic test_ignored_start();
        int          n_done = 0;
        int          first_at = 0;
        logic [11:0] first_bcd = '0;
        logic        first_neg = 1'b0;
        accept(8'h2A);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    first_at  = k;
                    first_bcd = bcd;
                    first_neg = neg;
                end
            end
            if (k == 3) begin
                sm_in = 8'h99;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL ign_count: got %0d expected 1", n_done); end
        n_checks++; if (first_at != LAT) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", first_at, LAT); end
        n_checks++; if (first_bcd !== ref_bcd(8'h2A)) begin n_fail++; $display("FAIL ign_bcd: got %h expected %h", first_bcd, ref_bcd(8'h2A)); end
        n_checks++; if (first_neg !== ref_neg(8'h2A)) begin n_fail++; $display("FAIL ign_neg: got %b expected %b", first_neg, ref_neg(8'h2A)); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int n_done = 0;
        accept(8'h7F);
        wait_done(lat);
        accept(8'h85);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (k == 3) rst_n = 1'b0;
            if (k == 4) begin
                n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", ready); end
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
                n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL abort_neg: got %b expected 0", neg); end
                n_checks++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd: got %h expected 000", bcd); end
                rst_n = 1'b1;
            end
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
        accept(8'h9B);
        wait_done(lat);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL abort_recover_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (bcd !== ref_bcd(8'h9B)) begin n_fail++; $display("FAIL abort_recover_bcd: got %h expected %h", bcd, ref_bcd(8'h9B)); end
        n_checks++; if (neg !== ref_neg(8'h9B)) begin n_fail++; $display("FAIL abort_recover_neg: got %b expected %b", neg, ref_neg(8'h9B)); end
    endtask

    task automatic test_random();
        logic [7:0]  v;
        logic [11:0] prev_bcd;
        logic        prev_neg;
        logic        held;
        int          lat;
        int          idle;
        for (int it = 0; it < 150; it++) begin
            v    = 8'($urandom);
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                @(posedge clk); #1;
            end
            prev_bcd = bcd;
            prev_neg = neg;
            accept(v);
            held = 1'b1;
            lat  = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) begin
                    lat = k;
                    break;
                end
                if (bcd !== prev_bcd || neg !== prev_neg) held = 1'b0;
            end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rnd_hold %h: outputs changed before done", v); end
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_latency %h: got %0d expected %0d", v, lat, LAT); end
            n_checks++; if (bcd !== ref_bcd(v)) begin n_fail++; $display("FAIL rnd_bcd %h: got %h expected %h", v, bcd, ref_bcd(v)); end
            n_checks++; if (neg !== ref_neg(v)) begin n_fail++; $display("FAIL rnd_neg %h: got %b expected %b", v, neg, ref_neg(v)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sm_in = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        @(posedge clk); #1;
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
